// File: rtl/io_cfg_pkg.sv
// ---------------------------------------------------------------------------
// io_cfg_pkg
// Shared types and constants for the IO bank configuration sequencer.
//   - cfg_state_e      : sequencer state encoding (also exported on state_dbg)
//   - DEF_*            : default geometry and bl/wl timing
//   - timer_width()    : width of the shared SETUP/PULSE/HOLD down-counter
//   - row_width()      : width of the word-line row index
// ---------------------------------------------------------------------------
package io_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } cfg_state_e;

  localparam int DEF_NUM_BL    = 8;
  localparam int DEF_NUM_WL    = 1;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  // The counter is loaded with (cycles - 1), so it only has to hold
  // max(SETUP, PULSE, HOLD) - 1; never narrower than one bit.
  function automatic int timer_width(input int setup_cyc, input int pulse_cyc,
                                     input int hold_cyc);
    int m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  function automatic int row_width(input int num_wl);
    return (num_wl <= 2) ? 1 : $clog2(num_wl);
  endfunction

endpackage

// File: rtl/cfg_pulse_timer.sv
// ---------------------------------------------------------------------------
// cfg_pulse_timer
// Loadable down-counter with a zero flag. The sequencer loads (cycles - 1) on
// every entry into SETUP, PULSE or HOLD; zero marks the last cycle of the
// phase. The counter parks at zero when not loaded.
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   load     in   load load_val on this edge
//   load_val in   W-bit reload value
//   zero     out  counter is zero (current phase ends this cycle)
// ---------------------------------------------------------------------------
module cfg_pulse_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/io_bank_config_sequencer.sv
// ---------------------------------------------------------------------------
// io_bank_config_sequencer
// Programs the memory-bank configuration cells of one IO grid tile over its
// bl/wl bus. One NUM_BL-bit word is taken per word line; for each row bl is
// driven, then wl[row] is pulsed with SETUP/PULSE/HOLD timing.
//
// Optional feature: define CFG_PARITY_EN to add the cfg_parity input (even
// parity over cfg_data), checked at the LOAD handshake. A mismatch skips the
// pulse, clears bl, sets error and returns to IDLE without done.
//
// Handshake: a word transfers on a prog_clk edge where cfg_valid and
// cfg_ready are both high; cfg_ready is high exactly while in LOAD and does
// not depend on cfg_valid; cfg_data must be stable while cfg_valid is high.
//
// Ports:
//   prog_clk      in   configuration clock
//   prog_reset_n  in   synchronous active-low reset
//   start         in   begin a pass (sampled only in IDLE)
//   abort         in   abandon the current pass
//   cfg_data      in   config word, cfg_data[i] drives bl[i]
//   cfg_valid     in   cfg_data valid
//   cfg_parity    in   even parity of cfg_data (CFG_PARITY_EN only)
//   cfg_ready     out  sequencer accepts a word
//   bl            out  bit lines
//   wl            out  word lines, one-hot or zero
//   busy          out  pass in progress
//   done          out  one-cycle pulse after the last row
//   error         out  sticky abort/parity flag, cleared by start
//   state_dbg     out  current FSM state
// ---------------------------------------------------------------------------
module io_bank_config_sequencer
  import io_cfg_pkg::*;
#(
  parameter int NUM_BL    = DEF_NUM_BL,
  parameter int NUM_WL    = DEF_NUM_WL,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_BL-1:0] cfg_data,
  input  logic              cfg_valid,
`ifdef CFG_PARITY_EN
  input  logic              cfg_parity,
`endif
  output logic              cfg_ready,
  output logic [0:NUM_BL-1] bl,
  output logic [0:NUM_WL-1] wl,
  output logic              busy,
  output logic              done,
  output logic              error,
  output cfg_state_e        state_dbg
);

  localparam int TMR_W = timer_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam int ROW_W = row_width(NUM_WL);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_WL - 1);
  localparam bit SKIP_SETUP = (SETUP_CYC == 0);
  localparam bit SKIP_HOLD  = (HOLD_CYC == 0);

  // Reload values; a zero-length phase is never entered, so its value is moot.
  localparam logic [TMR_W-1:0] SETUP_LD = (SETUP_CYC > 0) ? TMR_W'(SETUP_CYC - 1) : '0;
  localparam logic [TMR_W-1:0] PULSE_LD = (PULSE_CYC > 0) ? TMR_W'(PULSE_CYC - 1) : '0;
  localparam logic [TMR_W-1:0] HOLD_LD  = (HOLD_CYC > 0)  ? TMR_W'(HOLD_CYC - 1)  : '0;

  cfg_state_e       state;
  cfg_state_e       next_state;
  logic [ROW_W-1:0] row;
  logic [NUM_BL-1:0] bl_q;
  logic             error_q;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  logic             handshake;
  logic             abort_hit;
  logic             last_row;
  logic             par_fail;
  logic             row_adv;

`ifdef CFG_PARITY_EN
  assign par_fail = ((^cfg_data) != cfg_parity);
`else
  assign par_fail = 1'b0;
`endif

  assign handshake = (state == LOAD) && cfg_valid;
  assign abort_hit = abort && (state != IDLE);
  assign last_row  = (row == LAST_ROW);
  // Moving back to LOAD from the pulse phases means the next row is due.
  assign row_adv   = (next_state == LOAD) && ((state == PULSE) || (state == HOLD));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. abort overrides everything, including the handshake
  // and timer expiry in the same cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) next_state = LOAD;
      end
      LOAD: begin
        if (cfg_valid) begin
          if (par_fail)        next_state = IDLE;
          else if (SKIP_SETUP) next_state = PULSE;
          else                 next_state = SETUP;
        end
      end
      SETUP: begin
        if (tmr_zero) next_state = PULSE;
      end
      PULSE: begin
        if (tmr_zero) begin
          if (!SKIP_HOLD)    next_state = HOLD;
          else if (last_row) next_state = DONE;
          else               next_state = LOAD;
        end
      end
      HOLD: begin
        if (tmr_zero) next_state = last_row ? DONE : LOAD;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (abort_hit) next_state = IDLE;
  end

  // -------------------------------------------------------------------------
  // Timer reload on every state change, with the length of the phase entered.
  // -------------------------------------------------------------------------
  always_comb begin
    tmr_load = (next_state != state);
    tmr_val  = '0;
    unique case (next_state)
      SETUP:   tmr_val = SETUP_LD;
      PULSE:   tmr_val = PULSE_LD;
      HOLD:    tmr_val = HOLD_LD;
      default: tmr_val = '0;
    endcase
  end

  cfg_pulse_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (prog_clk),
    .rst_n    (prog_reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // -------------------------------------------------------------------------
  // Datapath registers: row index, bl word, sticky error.
  // bl only changes on the handshake edge (wl low before it) or on the way
  // back to IDLE, so it is stable across every wl pulse.
  // -------------------------------------------------------------------------
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      row     <= '0;
      bl_q    <= '0;
      error_q <= 1'b0;
    end else if (abort_hit) begin
      bl_q    <= '0;
      error_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            row     <= '0;
            error_q <= 1'b0;
          end
        end
        LOAD: begin
          if (handshake) begin
            if (par_fail) begin
              bl_q    <= '0;
              error_q <= 1'b1;
            end else begin
              bl_q <= cfg_data;
            end
          end
        end
        DONE: begin
          bl_q <= '0;
        end
        default: begin
          if (row_adv) row <= row + ROW_W'(1);
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode (Moore, from the registered state)
  // -------------------------------------------------------------------------
  always_comb begin
    cfg_ready = (state == LOAD);
    busy      = (state != IDLE);
    done      = (state == DONE);
    error     = error_q;
    state_dbg = state;
    bl        = '0;
    for (int i = 0; i < NUM_BL; i++) begin
      bl[i] = bl_q[i];
    end
    wl = '0;
    for (int i = 0; i < NUM_WL; i++) begin
      wl[i] = (state == PULSE) && (row == ROW_W'(i));
    end
  end

  // -------------------------------------------------------------------------
  // Bus-safety properties
  // -------------------------------------------------------------------------
  a_wl_onehot0: assert property (@(posedge prog_clk) disable iff (!prog_reset_n)
    $onehot0(wl));

  // bl may not move while wl stays high.
  a_bl_stable_in_pulse: assert property (@(posedge prog_clk) disable iff (!prog_reset_n)
    ((wl != '0) && ($past(wl) != '0)) |-> (bl == $past(bl)));

  // With a setup phase, bl is already settled when wl rises.
  a_bl_setup: assert property (@(posedge prog_clk) disable iff (!prog_reset_n)
    ((SETUP_CYC > 0) && (wl != '0) && ($past(wl) == '0)) |-> (bl == $past(bl)));

endmodule

// File: tb/tb_io_bank_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_io_bank_config_sequencer
// Three sequencer instances:
//   inst 0: NUM_WL=1, SETUP=1 PULSE=2 HOLD=1 (defaults)
//   inst 1: NUM_WL=4, defaults
//   inst 2: NUM_WL=2, SETUP=0 PULSE=2 HOLD=0
// A reference model describes each pass as a timeline counted from the
// handshake; every cycle the full output vector of each instance is compared
// to it. Directed tests add hand-computed latency and count expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_io_bank_config_sequencer;
  import io_cfg_pkg::*;

  localparam int NI = 3;
  localparam int NWL_P   [NI] = '{1, 4, 2};
  localparam int SETUP_P [NI] = '{1, 1, 0};
  localparam int PULSE_P [NI] = '{2, 2, 2};
  localparam int HOLD_P  [NI] = '{1, 1, 0};

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_DONE = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic [NI-1:0] start_v, abort_v, valid_v, par_v;
  logic [7:0]    data_a [NI];
  wire  [NI-1:0] ready_v, busy_v, done_v, err_v;
  wire  [0:7]    bl0, bl1, bl2;
  wire  [0:0]    wl0;
  wire  [0:3]    wl1;
  wire  [0:1]    wl2;
  cfg_state_e    st0, st1, st2;

  io_bank_config_sequencer #(.NUM_BL(8), .NUM_WL(1), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) u_dut0 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .cfg_data(data_a[0]), .cfg_valid(valid_v[0]),
`ifdef CFG_PARITY_EN
    .cfg_parity(par_v[0]),
`endif
    .cfg_ready(ready_v[0]), .bl(bl0), .wl(wl0), .busy(busy_v[0]), .done(done_v[0]),
    .error(err_v[0]), .state_dbg(st0));

  io_bank_config_sequencer #(.NUM_BL(8), .NUM_WL(4), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) u_dut1 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .cfg_data(data_a[1]), .cfg_valid(valid_v[1]),
`ifdef CFG_PARITY_EN
    .cfg_parity(par_v[1]),
`endif
    .cfg_ready(ready_v[1]), .bl(bl1), .wl(wl1), .busy(busy_v[1]), .done(done_v[1]),
    .error(err_v[1]), .state_dbg(st1));

  io_bank_config_sequencer #(.NUM_BL(8), .NUM_WL(2), .SETUP_CYC(0), .PULSE_CYC(2), .HOLD_CYC(0)) u_dut2 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
    .cfg_data(data_a[2]), .cfg_valid(valid_v[2]),
`ifdef CFG_PARITY_EN
    .cfg_parity(par_v[2]),
`endif
    .cfg_ready(ready_v[2]), .bl(bl2), .wl(wl2), .busy(busy_v[2]), .done(done_v[2]),
    .error(err_v[2]), .state_dbg(st2));

  // Normalised views: bl_v[k][i] is bl[i], wl_v[k][i] is wl[i].
  logic [7:0] bl_v [NI];
  logic [3:0] wl_v [NI];
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      bl_v[0][i] = bl0[i];
      bl_v[1][i] = bl1[i];
      bl_v[2][i] = bl2[i];
    end
    wl_v[0] = {3'b000, wl0[0]};
    for (int i = 0; i < 4; i++) wl_v[1][i] = wl1[i];
    wl_v[2] = {2'b00, wl2[1], wl2[0]};
  end

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         m_ph  [NI] = '{default: 0};
  int         m_t   [NI] = '{default: 0};
  int         m_row [NI] = '{default: 0};
  logic [7:0] m_bl  [NI] = '{default: 8'h00};
  logic       m_err [NI] = '{default: 1'b0};

  int         hs_cyc   [NI] = '{default: -10};
  int         done_cyc [NI] = '{default: -10};
  int         done_cnt [NI] = '{default: 0};
  int         rise_cyc [NI] = '{default: -10};
  logic [7:0] first_bl [NI] = '{default: 8'h00};
  logic [3:0] wl_prev  [NI] = '{default: 4'h0};
  int         wl_cnt   [NI][4];
  int         hs2_q[$];
  int         rise2_q[$];
  logic [1:0] exp_q[$];   // expected word-line order on instance 1

  initial begin
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 4; i++) wl_cnt[k][i] = 0;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A pass row is a timeline t = 1 .. SETUP+PULSE+HOLD after the handshake;
  // wl[row] is high for SETUP < t <= SETUP+PULSE.
  function automatic logic [15:0] exp_vec(input int k);
    logic [3:0] w;
    w = 4'h0;
    if (m_ph[k] == PH_RUN && m_t[k] > SETUP_P[k] && m_t[k] <= SETUP_P[k] + PULSE_P[k])
      w = 4'(1 << m_row[k]);
    return {m_ph[k] == PH_LOAD, m_ph[k] != PH_IDLE, m_ph[k] == PH_DONE, m_err[k], w, m_bl[k]};
  endfunction

  logic pf;
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
`ifdef CFG_PARITY_EN
      pf = (par_v[k] != ^data_a[k]);
`else
      pf = 1'b0;
`endif
      if (!rst_n) begin
        m_ph[k] = PH_IDLE; m_t[k] = 0; m_row[k] = 0; m_bl[k] = 8'h00; m_err[k] = 1'b0;
      end else if (abort_v[k] && m_ph[k] != PH_IDLE) begin
        m_ph[k] = PH_IDLE; m_bl[k] = 8'h00; m_err[k] = 1'b1;
      end else begin
        case (m_ph[k])
          PH_IDLE: if (start_v[k]) begin
            m_ph[k] = PH_LOAD; m_row[k] = 0; m_err[k] = 1'b0;
          end
          PH_LOAD: if (valid_v[k]) begin
            if (pf) begin
              m_ph[k] = PH_IDLE; m_bl[k] = 8'h00; m_err[k] = 1'b1;
            end else begin
              m_bl[k] = data_a[k]; m_t[k] = 1; m_ph[k] = PH_RUN;
              hs_cyc[k] = cyc;
              if (k == 2) hs2_q.push_back(cyc);
            end
          end
          PH_RUN: begin
            if (m_t[k] == SETUP_P[k] + PULSE_P[k] + HOLD_P[k]) begin
              if (m_row[k] == NWL_P[k] - 1) m_ph[k] = PH_DONE;
              else begin
                m_row[k] = m_row[k] + 1; m_ph[k] = PH_LOAD;
              end
            end else begin
              m_t[k] = m_t[k] + 1;
            end
          end
          default: begin
            m_ph[k] = PH_IDLE; m_bl[k] = 8'h00;
          end
        endcase
      end
    end
    cyc++;
  end

  // ---------------- compare / monitor ----------------
  logic [15:0] act_vec, want_vec;
  logic [1:0]  want_row;
  int          obs_row;
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < NI; k++) begin
        act_vec  = {ready_v[k], busy_v[k], done_v[k], err_v[k], wl_v[k], bl_v[k]};
        want_vec = exp_vec(k);
        total++;
        if (act_vec !== want_vec) begin
          bad++;
          $display("FAIL model_cmp inst=%0d cyc=%0d got={rdy,busy,done,err,wl,bl}=%h expected %h",
                   k, cyc, act_vec, want_vec);
        end
        if (done_v[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
        end
        if (cyc == hs_cyc[k] + 1) first_bl[k] = bl_v[k];
        for (int i = 0; i < 4; i++) if (wl_v[k][i]) wl_cnt[k][i]++;
        if (wl_v[k] != 4'h0 && wl_prev[k] == 4'h0) begin
          rise_cyc[k] = cyc;
          if (k == 2) rise2_q.push_back(cyc);
          if (k == 1) begin
            obs_row = 0;
            for (int i = 0; i < 4; i++) if (wl_v[1][i]) obs_row = i;
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL wl_order: row %0d pulsed with no row expected", obs_row);
            end else begin
              want_row = exp_q.pop_front();
              if (obs_row != int'(want_row)) begin
                bad++;
                $display("FAIL wl_order: got row %0d expected row %0d", obs_row, want_row);
              end
            end
          end
        end
        wl_prev[k] = wl_v[k];
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int k);
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
  endtask

  // Offers one word after `gap` idle cycles; returns one cycle after the
  // handshake edge (#1 past it).
  task automatic send_word(input int k, input logic [7:0] d, input logic p, input int gap);
    repeat (gap) tick();
    data_a[k]  = d;
    par_v[k]   = p;
    valid_v[k] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ready_v[k]) begin
        tick();
        valid_v[k] = 1'b0;
        return;
      end
    end
    valid_v[k] = 1'b0;
    total++; bad++;
    $display("FAIL send_word_timeout: inst %0d never ready, got 0 expected 1", k);
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_done(input int k);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done_v[k]) return;
    end
    total++; bad++;
    $display("FAIL wait_done_timeout: inst %0d done got 0 expected 1", k);
  endtask

  // ---------------- stimulus ----------------
  int wl_before;
  logic [7:0] w4 [4];

  initial begin
    rst_n = 1'b0; start_v = '0; abort_v = '0; valid_v = '0; par_v = '0;
    for (int k = 0; k < NI; k++) data_a[k] = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out0", {ready_v[0], busy_v[0], done_v[0], err_v[0], wl_v[0], bl_v[0]}, 0);
    check("rst_out1", {ready_v[1], busy_v[1], done_v[1], err_v[1], wl_v[1], bl_v[1]}, 0);
    check("rst_out2", {ready_v[2], busy_v[2], done_v[2], err_v[2], wl_v[2], bl_v[2]}, 0);
    check("rst_state0", st0, IDLE);
    check("rst_state1", st1, IDLE);
    check("rst_state2", st2, IDLE);
    rst_n = 1'b1;
    tick();

    // T1: single word A5 on the default-timing, single-row instance.
    pulse_start(0);
    send_word(0, 8'hA5, ^8'hA5, 0);
    wait_done(0);
    tick();
    check("t1_done_latency", done_cyc[0] - hs_cyc[0], 5);
    check("t1_bl_after_hs", first_bl[0], 8'hA5);
    check("t1_wl_rise_offset", rise_cyc[0] - hs_cyc[0], 2);
    check("t1_wl_cycles", wl_cnt[0][0], 2);
    check("t1_done_count", done_cnt[0], 1);

    // T2: four rows with 3-cycle valid gaps.
    w4 = '{8'h11, 8'h22, 8'h3C, 8'hF0};
    for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
    pulse_start(1);
    for (int i = 0; i < 4; i++) send_word(1, w4[i], ^w4[i], 3);
    wait_done(1);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) check($sformatf("t2_wl%0d_cycles", i), wl_cnt[1][i], 2);
    check("t2_done_count", done_cnt[1], 1);
    check("t2_rows_left", exp_q.size(), 0);

    // T3: abort in the second PULSE cycle.
    pulse_start(0);
    send_word(0, 8'h3C, ^8'h3C, 0);   // now in SETUP
    tick();                           // PULSE 1
    tick();                           // PULSE 2
    abort_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    @(negedge clk);
    check("t3_abort_out", {ready_v[0], busy_v[0], done_v[0], err_v[0], wl_v[0], bl_v[0]}, 16'h1000);
    repeat (8) tick();
    check("t3_no_done", done_cnt[0], 1);
    check("t3_wl_cycles", wl_cnt[0][0], 4);

    // T4: reset in PULSE, then start while busy and start in the done cycle.
    pulse_start(0);
    send_word(0, 8'h5A, ^8'h5A, 0);   // SETUP
    tick();                           // PULSE 1
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("t4_reset_out", {ready_v[0], busy_v[0], done_v[0], err_v[0], wl_v[0], bl_v[0]}, 0);
    rst_n = 1'b1;
    tick();
    pulse_start(0);
    send_word(0, 8'h96, ^8'h96, 0);
    start_v[0] = 1'b1;                // ignored: busy
    tick();
    start_v[0] = 1'b0;
    wait_done(0);
    start_v[0] = 1'b1;                // ignored: same cycle as done
    tick();
    start_v[0] = 1'b0;
    tick();
    @(negedge clk);
    check("t4_idle_after_done", busy_v[0], 0);
    check("t4_done_count", done_cnt[0], 2);

    // T5: zero setup/hold, two rows back to back.
    hs2_q.delete();
    rise2_q.delete();
    tick();
    pulse_start(2);
    send_word(2, 8'hC3, ^8'hC3, 0);
    send_word(2, 8'h81, ^8'h81, 0);
    wait_done(2);
    tick();
    check("t5_hs_count", hs2_q.size(), 2);
    check("t5_rise_count", rise2_q.size(), 2);
    if (hs2_q.size() == 2 && rise2_q.size() == 2) begin
      check("t5_row_period", hs2_q[1] - hs2_q[0], 3);
      check("t5_rise0_offset", rise2_q[0] - hs2_q[0], 1);
      check("t5_rise1_offset", rise2_q[1] - hs2_q[1], 1);
      check("t5_done_latency", done_cyc[2] - hs2_q[1], 3);
    end
    check("t5_wl0_cycles", wl_cnt[2][0], 2);
    check("t5_wl1_cycles", wl_cnt[2][1], 2);

`ifdef CFG_PARITY_EN
    // T6: bad parity, then a good retry.
    wl_before = wl_cnt[0][0];
    pulse_start(0);
    send_word(0, 8'h01, 1'b0, 0);
    @(negedge clk);
    check("t6_err_set", err_v[0], 1);
    check("t6_not_busy", busy_v[0], 0);
    repeat (4) tick();
    check("t6_no_wl", wl_cnt[0][0], wl_before);
    pulse_start(0);
    send_word(0, 8'h01, 1'b1, 0);
    wait_done(0);
    tick();
    check("t6_retry_done", done_cnt[0], 3);
    check("t6_err_cleared", err_v[0], 0);
`else
    wl_before = 0;
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
